tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter N_CH, default 4, number of time slots (channels) per frame; legal range 2..16.
REQ-002 Parameter W, default 8, width in bits of one slot word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  slot word present on in_data this cycle.
REQ-006 in_sof  input  1  start of frame; qualified by in_valid; marks the word as slot 0.
REQ-007 in_data  input  W  serial TDM slot word.
REQ-008 out_valid  output  1  one-cycle pulse: complete frame available on out_data.
REQ-009 out_data  output  N_CH*W  last complete frame; slot k at bits [k*W +: W].
REQ-010 frame_err  output  1  one-cycle pulse: partial frame discarded.
REQ-011 slot_idx  output  $clog2(N_CH)  index of the next slot expected in COLLECT; 0 in IDLE.
REQ-012 frame_cnt  output  8  completed frames, wraps 255->0.
REQ-013 err_cnt  output  8  discarded frames, saturates at 255.

Function
REQ-014 FSM has two states: IDLE (waiting for sof) and COLLECT (filling slots 1..N_CH-1).
REQ-015 Words with in_valid=0 are ignored in every state; gaps of any length between slots are legal and do not alter state.
REQ-016 IDLE, in_valid=1, in_sof=0: word dropped, no error, state unchanged.
REQ-017 IDLE, in_valid=1, in_sof=1: word stored in shadow slot 0, slot_idx<=1, state<=COLLECT.
REQ-018 COLLECT, in_valid=1, in_sof=0: word stored in shadow slot slot_idx, slot_idx increments.
REQ-019 Word accepted into slot N_CH-1: state<=IDLE, slot_idx<=0; next cycle out_valid=1, out_data=full shadow frame, frame_cnt increments.
REQ-020 out_data updates atomically only on frame completion; holds its value otherwise, including during partial frames and errors.
REQ-021 COLLECT, in_valid=1, in_sof=1 (early sof): next cycle frame_err=1, err_cnt increments unless at 255; the new word is stored as slot 0, slot_idx<=1, state stays COLLECT.
REQ-022 Early sof never produces out_valid; discarded shadow slots are never visible on out_data.
REQ-023 Back-to-back frames: sof accepted the cycle after the last slot of the previous frame (state already IDLE); zero bubble required.
REQ-024 out_valid and frame_err are never asserted in the same cycle.
REQ-025 Latency from acceptance of last slot word to out_valid is exactly 1 cycle; out_valid is a single-cycle pulse.

Reset
REQ-026 rst_n=0 immediately forces: state=IDLE, slot_idx=0, out_valid=0, frame_err=0, out_data=0, frame_cnt=0, err_cnt=0, shadow slots=0.
REQ-027 Reset mid-frame discards the partial frame without frame_err or out_valid; first action after release is awaiting in_sof.
REQ-028 Deassertion of rst_n is sampled at a clk edge; no word is accepted in the cycle reset releases asynchronously between edges.

Verification (N_CH=4, W=8)
REQ-029 Reset, then sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> one cycle after 0x44, out_valid=1, out_data=0x44332211, frame_cnt=1.
REQ-030 Same frame with 3 idle cycles between each slot -> identical out_data, out_valid exactly once, no frame_err.
REQ-031 Words 0xAA, 0xBB without sof in IDLE, then valid frame 0x01..0x04 -> out_data=0x04030201, err_cnt=0.
REQ-032 sof+0x10, 0x20, then sof+0x50, 0x60, 0x70, 0x80 -> frame_err pulse after second sof, err_cnt=1, out_data=0x80706050, 0x10/0x20 never appear.
REQ-033 Two frames back-to-back with no gap -> two out_valid pulses 4 cycles apart, frame_cnt=2.
REQ-034 rst_n low after 2 slots, release, then full frame 0xDEADBEEF slot order EF,BE,AD,DE -> no frame_err, out_data=0xDEADBEEF, frame_cnt=1.

Source files
------------

// File: rtl/tdm_demux_if.sv
// tdm_demux_if
// Groups the serial TDM input stream and the demultiplexed frame outputs of
// tdm_demux into one bundle.
//
// Signals
//   in_valid   slot word present on in_data this cycle
//   in_sof     start of frame, qualified by in_valid; word is slot 0
//   in_data    serial slot word (W bits)
//   out_valid  one-cycle pulse: complete frame on out_data
//   out_data   last complete frame, slot k at [k*W +: W]
//   frame_err  one-cycle pulse: partial frame discarded
//   slot_idx   next slot expected while collecting, 0 when idle
//   frame_cnt  completed frames, wraps
//   err_cnt    discarded frames, saturates
//
// Modports
//   master  stream source / frame consumer (testbench or upstream logic)
//   slave   the demultiplexer itself
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  localparam int IW = $clog2(N_CH);

  logic              in_valid;
  logic              in_sof;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic [N_CH*W-1:0] out_data;
  logic              frame_err;
  logic [IW-1:0]     slot_idx;
  logic [7:0]        frame_cnt;
  logic [7:0]        err_cnt;

  modport master (
    output in_valid,
    output in_sof,
    output in_data,
    input  out_valid,
    input  out_data,
    input  frame_err,
    input  slot_idx,
    input  frame_cnt,
    input  err_cnt
  );

  modport slave (
    input  in_valid,
    input  in_sof,
    input  in_data,
    output out_valid,
    output out_data,
    output frame_err,
    output slot_idx,
    output frame_cnt,
    output err_cnt
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux
// Collects N_CH serial slot words into a shadow frame and publishes the whole
// frame at once when the last slot arrives. A start-of-frame seen while a
// frame is still being collected discards the partial frame and restarts
// collection with the new word as slot 0.
//
// Ports
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    tdm_demux_if.slave: in_valid/in_sof/in_data stream in,
//          out_valid/out_data/frame_err/slot_idx/frame_cnt/err_cnt out
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a word with in_sof; other valid words dropped
// COLLECT | slot 0 held in shadow, filling slots 1..N_CH-1
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux_if.slave  bus
);
  localparam int IW = $clog2(N_CH);
  localparam logic [IW-1:0] LAST_SLOT = IW'(N_CH - 1);
  localparam logic [IW-1:0] SLOT_ONE  = IW'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                  state;
  logic [N_CH-1:0][W-1:0]  shadow;
  logic [N_CH-1:0][W-1:0]  frame_next;
  logic [IW-1:0]           slot_idx_q;
  logic                    out_valid_q;
  logic                    frame_err_q;
  logic [N_CH*W-1:0]       out_data_q;
  logic [7:0]              frame_cnt_q;
  logic [7:0]              err_cnt_q;

  // The last word goes straight into the published frame, so out_data can
  // update on the same edge that accepts it (one-cycle latency).
  always_comb begin
    frame_next            = shadow;
    frame_next[N_CH-1]    = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shadow      <= '0;
      slot_idx_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      out_data_q  <= '0;
      frame_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          IDLE: begin
            if (bus.in_sof) begin
              shadow[0]  <= bus.in_data;
              slot_idx_q <= SLOT_ONE;
              state      <= COLLECT;
            end
          end
          COLLECT: begin
            if (bus.in_sof) begin
              // Early sof: old slots stay in shadow but are overwritten
              // before any later completion can publish them.
              frame_err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
              shadow[0]  <= bus.in_data;
              slot_idx_q <= SLOT_ONE;
            end else if (slot_idx_q == LAST_SLOT) begin
              shadow[N_CH-1] <= bus.in_data;
              out_data_q     <= frame_next;
              out_valid_q    <= 1'b1;
              frame_cnt_q    <= frame_cnt_q + 8'd1;
              slot_idx_q     <= '0;
              state          <= IDLE;
            end else begin
              shadow[slot_idx_q] <= bus.in_data;
              slot_idx_q         <= slot_idx_q + SLOT_ONE;
            end
          end
          default: begin
            state      <= IDLE;
            slot_idx_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.out_data  = out_data_q;
  assign bus.slot_idx  = slot_idx_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux
// Drives directed frame scenarios followed by a randomized stream against
// tdm_demux (N_CH=4, W=8). Expected outputs come from a queue-based model of
// the frame rules: words of the frame in progress sit in a queue, a full queue
// becomes a published frame, an sof on a non-empty queue is a discard.
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  cur[$];
  logic [31:0] m_data;
  logic        m_ov;
  logic        m_fe;
  logic [7:0]  m_fcnt;
  int          m_ecnt;
  int          ov_seen;
  int          fe_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    m_data = 32'h0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    m_fcnt = 8'd0;
    m_ecnt = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [7:0] d);
    m_ov = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      if (s) begin
        if (cur.size() != 0) begin
          m_fe = 1'b1;
          if (m_ecnt < 255) m_ecnt++;
        end
        cur.delete();
        cur.push_back(d);
      end else if (cur.size() != 0) begin
        cur.push_back(d);
        if (cur.size() == N_CH) begin
          for (int k = 0; k < N_CH; k++) m_data[k*8 +: 8] = cur[k];
          m_ov = 1'b1;
          m_fcnt = m_fcnt + 8'd1;
          cur.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_ov});
    chk({ctx, ":frame_err"}, {31'd0, bus.frame_err}, {31'd0, m_fe});
    chk({ctx, ":out_data"},  bus.out_data, m_data);
    chk({ctx, ":slot_idx"},  {30'd0, bus.slot_idx}, 32'(cur.size()));
    chk({ctx, ":frame_cnt"}, {24'd0, bus.frame_cnt}, {24'd0, m_fcnt});
    chk({ctx, ":err_cnt"},   {24'd0, bus.err_cnt}, 32'(m_ecnt));
    if (bus.out_valid) ov_seen++;
    if (bus.frame_err) fe_seen++;
  endtask

  // one clock: drive inputs, let the edge take them, compare one step later
  task automatic cyc(input string ctx, input logic v, input logic s, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    model_step(v, s, d);
    check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) cyc(ctx, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  // asynchronous assert and release, both between clock edges
  task automatic do_reset(input string ctx);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({ctx, ":rst"});
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all({ctx, ":rel"});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    rst_n        = 1'b1;
    model_reset();
    #2;
    do_reset("init");

    // consecutive frame
    ov_seen = 0;
    cyc("f1", 1, 1, 8'h11);
    cyc("f1", 1, 0, 8'h22);
    cyc("f1", 1, 0, 8'h33);
    cyc("f1", 1, 0, 8'h44);
    chk("f1:data_lit", bus.out_data, 32'h44332211);
    chk("f1:cnt_lit", {24'd0, bus.frame_cnt}, 32'd1);
    idle("f1", 2);

    // gaps between slots
    ov_seen = 0; fe_seen = 0;
    cyc("gap", 1, 1, 8'h11); idle("gap", 3);
    cyc("gap", 1, 0, 8'h22); idle("gap", 3);
    cyc("gap", 1, 0, 8'h33); idle("gap", 3);
    cyc("gap", 1, 0, 8'h44); idle("gap", 3);
    chk("gap:data_lit", bus.out_data, 32'h44332211);
    chk("gap:ov_once", 32'(ov_seen), 32'd1);
    chk("gap:no_err", 32'(fe_seen), 32'd0);

    // words without sof in IDLE are dropped
    cyc("nosof", 1, 0, 8'hAA);
    cyc("nosof", 1, 0, 8'hBB);
    cyc("nosof", 1, 1, 8'h01);
    cyc("nosof", 1, 0, 8'h02);
    cyc("nosof", 1, 0, 8'h03);
    cyc("nosof", 1, 0, 8'h04);
    chk("nosof:data_lit", bus.out_data, 32'h04030201);
    chk("nosof:err_lit", {24'd0, bus.err_cnt}, 32'd0);
    idle("nosof", 1);

    // early sof discards partial frame
    do_reset("es");
    cyc("es", 1, 1, 8'h10);
    cyc("es", 1, 0, 8'h20);
    cyc("es", 1, 1, 8'h50);
    chk("es:fe_lit", {31'd0, bus.frame_err}, 32'd1);
    cyc("es", 1, 0, 8'h60);
    cyc("es", 1, 0, 8'h70);
    cyc("es", 1, 0, 8'h80);
    chk("es:data_lit", bus.out_data, 32'h80706050);
    chk("es:err_lit", {24'd0, bus.err_cnt}, 32'd1);
    idle("es", 1);

    // back-to-back frames, zero bubble
    do_reset("b2b");
    ov_seen = 0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N_CH; k++)
        cyc("b2b", 1, k == 0, 8'(8'hA0 + f * 16 + k));
    chk("b2b:ov_count", 32'(ov_seen), 32'd2);
    chk("b2b:cnt_lit", {24'd0, bus.frame_cnt}, 32'd2);
    idle("b2b", 1);

    // reset mid-frame
    do_reset("mr");
    cyc("mr", 1, 1, 8'h12);
    cyc("mr", 1, 0, 8'h34);
    fe_seen = 0;
    do_reset("mr");
    cyc("mr", 1, 1, 8'hEF);
    cyc("mr", 1, 0, 8'hBE);
    cyc("mr", 1, 0, 8'hAD);
    cyc("mr", 1, 0, 8'hDE);
    chk("mr:data_lit", bus.out_data, 32'hDEADBEEF);
    chk("mr:cnt_lit", {24'd0, bus.frame_cnt}, 32'd1);
    chk("mr:no_err", 32'(fe_seen), 32'd0);
    idle("mr", 1);

    // randomized stream with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 3);
      if (i % 500 == 499) do_reset("rnd");
      cyc("rnd", v, s, 8'($urandom_range(0, 255)));
    end

    // drive err_cnt toward saturation with repeated early sofs
    do_reset("sat");
    for (int i = 0; i < 262; i++) cyc("sat", 1, 1, 8'(i));
    chk("sat:err_lit", {24'd0, bus.err_cnt}, 32'd255);
    idle("sat", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
